recovery_restore_engine: RTL and testbench
==========================================

# recovery_restore_engine

Sequencer that drains the recovery register file back into the core after a total TMR collapse. On a start pulse it walks architectural registers x1..x31, reading each word through the recovery register's combinational read port and replaying it as a write on the core register-file write port. It asserts a hold to the core while busy and pulses done on completion. x0 is never restored.

## Interface
Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- LAST_ADDR, 31, final register index restored; first index is fixed at 1

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_in  in  1  synchronous, active-high reset
- start_in  in  1  restore request, sampled only in IDLE
- A1  out  ADDR_W  read address to recovery register
- RD1  in  DATA_W  read data from recovery register (combinational on A1)
- WE3  out  1  core register-file write enable
- A3  out  ADDR_W  core register-file write address
- WD3  out  DATA_W  core register-file write data
- core_hold  out  1  stall request to core pipeline
- busy  out  1  restore in progress
- done  out  1  one-cycle completion pulse
- chk_in  in  DATA_W  expected XOR checksum of x1..x31
- chk_err  out  1  checksum mismatch flag

## Operation
- States: IDLE, RESTORE, DONE. Internal rd_addr (ADDR_W), checksum accumulator acc (DATA_W).
- IDLE: rd_addr=1, acc=0. start_in=1 at edge → RESTORE; otherwise stay.
- RESTORE, each edge: WE3<=1, A3<=rd_addr, WD3<=RD1, acc<=acc^RD1. rd_addr==LAST_ADDR → DONE, else rd_addr<=rd_addr+1 (no wrap; never exceeds LAST_ADDR).
- DONE, one edge: WE3<=0, done<=1, chk_err updated (see Configuration), → IDLE, rd_addr<=1.
- busy = core_hold = (state != IDLE), decoded from state register.
- A1 = rd_addr when state==RESTORE, else 0.
- WE3, A3, WD3, done, chk_err are registered. A3/WD3 hold last values when WE3=0.
- start_in in RESTORE or DONE: ignored, no queueing.
- Reset values: state IDLE, rd_addr 1, acc 0, WE3 0, A3 0, WD3 0, done 0, chk_err 0, busy 0, core_hold 0, A1 0.
- rst_in mid-restore: all of the above at next edge; no further writes issued; partially restored registers are left as written. rst_in and start_in together: reset wins.

## Timing
- start_in high in cycle 0 (IDLE) → RESTORE cycles 1..31, A1=k in cycle k.
- WE3=1 cycles 2..32, with A3=k-1 and WD3 = RD1 sampled in cycle k-1.
- Cycle 32: state DONE, last write (A3=31) visible.
- Cycle 33: done=1, busy=0, WE3=0; done low again in cycle 34.
- Total: 31 writes, busy for 32 cycles, done 33 cycles after start.
- New start_in accepted in cycle 33 (same cycle as done); next A1=1 in cycle 34.
- RD1 must be stable within the cycle A1 is driven; no wait states.

## Configuration
- RESTORE_CHECKSUM_EN defined: in DONE, chk_err <= ((acc^RD1-free final acc) != chk_in), i.e. the XOR of all 31 restored words compared against chk_in; chk_err visible with done and held until next accepted start (cleared on the edge leaving IDLE) or reset. chk_err has no effect on the restore itself.
- Not defined: acc logic absent, chk_in ignored, chk_err tied 0.

## Test plan
- Recovery register preloaded with xk = 0x1000_0000+k; pulse start_in → 31 writes in cycles 2..32, A3=1..31, WD3=0x1000_0001..0x1000_001F; done only in cycle 33; A3 never 0.
- start_in held high continuously → restore repeats: done cycle 33, A1=1 again cycle 34, second done cycle 66; no start captured while busy.
- rst_in asserted in cycle 10 → cycle 11: WE3=0, busy=0, A1=0, done never asserted; next start restarts from x1.
- rst_in and start_in both high in the same cycle → remains IDLE, no WE3 pulse.
- RESTORE_CHECKSUM_EN, words all 0xFFFF_FFFF (31 words → XOR 0xFFFF_FFFF): chk_in=0xFFFF_FFFF → chk_err=0 in cycle 33; chk_in=0 → chk_err=1, held until next start.
- Without RESTORE_CHECKSUM_EN: any chk_in → chk_err stays 0 for all cycles.

Source files
------------

// File: rtl/recovery_restore_engine.sv
// Replays recovery-register words x1..LAST_ADDR into the core register file after a TMR collapse.
// Optional RESTORE_CHECKSUM_EN: XOR-checks the replayed words against chk_in and flags chk_err.
module recovery_restore_engine #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int LAST_ADDR = 31
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              start_in,
  output logic [ADDR_W-1:0] A1,
  input  logic [DATA_W-1:0] RD1,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] chk_in,
  output logic              chk_err
);

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {IDLE, RESTORE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] rd_addr_reg;

  always_ff @(posedge clk) begin
    if (rst_in) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // start_in is only looked at in IDLE, so requests while busy are dropped
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_in) state_next = RESTORE;
      RESTORE: if (rd_addr_reg == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      rd_addr_reg <= FIRST;
      WE3         <= 1'b0;
      A3          <= '0;
      WD3         <= '0;
      done        <= 1'b0;
    end else begin
      WE3  <= 1'b0;
      done <= 1'b0;
      case (state_reg)
        RESTORE: begin
          WE3 <= 1'b1;
          A3  <= rd_addr_reg;
          WD3 <= RD1;
          if (rd_addr_reg != LAST) rd_addr_reg <= rd_addr_reg + FIRST;
        end
        DONE: begin
          done        <= 1'b1;
          rd_addr_reg <= FIRST;
        end
        default: rd_addr_reg <= FIRST;
      endcase
    end
  end

  assign busy      = (state_reg != IDLE);
  assign core_hold = busy;
  assign A1        = (state_reg == RESTORE) ? rd_addr_reg : '0;

`ifdef RESTORE_CHECKSUM_EN
  logic [DATA_W-1:0] acc_reg;
  logic              chk_err_reg;

  // acc already holds every restored word by the time DONE is reached
  always_ff @(posedge clk) begin
    if (rst_in) begin
      acc_reg     <= '0;
      chk_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        RESTORE: acc_reg <= acc_reg ^ RD1;
        DONE: begin
          chk_err_reg <= (acc_reg != chk_in);
          acc_reg     <= '0;
        end
        default: begin
          acc_reg <= '0;
          if (start_in) chk_err_reg <= 1'b0;
        end
      endcase
    end
  end

  assign chk_err = chk_err_reg;
`else
  logic unused_chk;
  assign unused_chk = ^chk_in;
  assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_recovery_restore_engine.sv
// Directed bench for recovery_restore_engine; models the recovery register as a combinational array.
// Checksum scenarios run only when RESTORE_CHECKSUM_EN is defined.
module tb_recovery_restore_engine;

  logic        clk;
  logic        rst_in;
  logic        start_in;
  logic [4:0]  A1;
  logic [31:0] RD1;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic [31:0] chk_in;
  logic        chk_err;

  logic [31:0] mem [0:31];
  int          checks;
  int          errors;

  recovery_restore_engine #(.ADDR_W(5), .DATA_W(32), .LAST_ADDR(31)) dut (
    .clk(clk), .rst_in(rst_in), .start_in(start_in),
    .A1(A1), .RD1(RD1),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .core_hold(core_hold), .busy(busy), .done(done),
    .chk_in(chk_in), .chk_err(chk_err)
  );

  assign RD1 = mem[A1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs in cycle p after the start edge (p=1 first RESTORE cycle, p=33 done cycle)
  task automatic check_cycle(input int p);
    logic        e_busy;
    logic        e_we;
    logic [31:0] e_a1;
    e_busy = (p >= 1) && (p <= 32);
    e_we   = (p >= 2) && (p <= 32);
    e_a1   = (p <= 31) ? p : 0;
    chk($sformatf("busy_c%0d", p), {31'd0, busy}, {31'd0, e_busy});
    chk($sformatf("hold_c%0d", p), {31'd0, core_hold}, {31'd0, e_busy});
    chk($sformatf("A1_c%0d", p), {27'd0, A1}, e_a1);
    chk($sformatf("WE3_c%0d", p), {31'd0, WE3}, {31'd0, e_we});
    chk($sformatf("done_c%0d", p), {31'd0, done}, {31'd0, (p == 33)});
    if (e_we) begin
      chk($sformatf("A3_c%0d", p), {27'd0, A3}, p - 1);
      chk($sformatf("WD3_c%0d", p), WD3, mem[p-1]);
    end
    if (p >= 33) begin
      chk($sformatf("A3hold_c%0d", p), {27'd0, A3}, 32'd31);
      chk($sformatf("WD3hold_c%0d", p), WD3, mem[31]);
    end
`ifndef RESTORE_CHECKSUM_EN
    chk($sformatf("chk_err_c%0d", p), {31'd0, chk_err}, 32'd0);
`endif
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_in   = 1'b1;
    start_in = 1'b0;
    chk_in   = 32'h1234_5678;
    mem[0]   = 32'hDEAD_BEEF;
    for (int k = 1; k < 32; k++) mem[k] = 32'h1000_0000 + k;

    // reset state
    step();
    step();
    chk("rst_WE3", {31'd0, WE3}, 32'd0);
    chk("rst_A3", {27'd0, A3}, 32'd0);
    chk("rst_WD3", WD3, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hold", {31'd0, core_hold}, 32'd0);
    chk("rst_A1", {27'd0, A1}, 32'd0);
    chk("rst_chk_err", {31'd0, chk_err}, 32'd0);
    rst_in = 1'b0;
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // single restore pass
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      check_cycle(c);
      step();
    end

    // start held high: back-to-back passes, done at 33 and 66
    start_in = 1'b1;
    step();
    for (int c = 1; c <= 67; c++) begin
      check_cycle(((c - 1) % 33) + 1);
      step();
    end
    start_in = 1'b0;
    rst_in   = 1'b1;
    step();
    rst_in = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_WE3", {31'd0, WE3}, 32'd0);

    // reset in cycle 10 of a pass
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check_cycle(c);
      if (c < 10) step();
    end
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk("mid_rst_WE3", {31'd0, WE3}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_A1", {27'd0, A1}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    for (int c = 0; c < 40; c++) begin
      step();
      chk("post_rst_done", {31'd0, done}, 32'd0);
      chk("post_rst_WE3", {31'd0, WE3}, 32'd0);
    end
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      check_cycle(c);
      step();
    end

    // reset and start together: reset wins
    rst_in   = 1'b1;
    start_in = 1'b1;
    step();
    rst_in   = 1'b0;
    start_in = 1'b0;
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_WE3", {31'd0, WE3}, 32'd0);
    chk("rs_A1", {27'd0, A1}, 32'd0);
    step();
    chk("rs_busy2", {31'd0, busy}, 32'd0);
    chk("rs_WE3_2", {31'd0, WE3}, 32'd0);

`ifdef RESTORE_CHECKSUM_EN
    // all-ones words: XOR of 31 words is 0xFFFF_FFFF
    for (int k = 1; k < 32; k++) mem[k] = 32'hFFFF_FFFF;
    chk_in   = 32'hFFFF_FFFF;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      check_cycle(c);
      step();
    end
    chk("cs_ok_done", {31'd0, done}, 32'd1);
    chk("cs_ok_err", {31'd0, chk_err}, 32'd0);
    step();
    chk_in   = 32'h0000_0000;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int c = 1; c <= 32; c++) step();
    chk("cs_bad_done", {31'd0, done}, 32'd1);
    chk("cs_bad_err", {31'd0, chk_err}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("cs_bad_hold", {31'd0, chk_err}, 32'd1);
    end
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    chk("cs_clear_busy", {31'd0, busy}, 32'd1);
    chk("cs_clear_err", {31'd0, chk_err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
